// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. Each stage ripples one WIDTH/STAGES-bit chunk
// and registers the carry. All stages advance together under a global valid/ready stall.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_neg
);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipe_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    localparam int C = WIDTH / STAGES;

    logic w_adv;

    // The whole pipe moves as one unit, so a stalled output freezes every stage, bubbles included.
    assign w_adv      = ~o_valid | i_out_ready;
    assign o_in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // IW: operand bits still unconsumed on arrival. SW: sum bits complete after this stage.
        localparam int IW = WIDTH - k * C;
        localparam int SW = (k + 1) * C;

        logic [IW-1:0] w_a_in;
        logic [IW-1:0] w_b_in;
        logic          w_sub_in;
        logic          w_cin;
        logic          w_valid_in;
        logic [C-1:0]  w_bx;
        logic [C:0]    w_chunk;
        logic [SW-1:0] w_sum_new;
        logic          r_valid;

        assign w_bx    = w_b_in[C-1:0] ^ {C{w_sub_in}};
        assign w_chunk = {1'b0, w_a_in[C-1:0]} + {1'b0, w_bx} + {{C{1'b0}}, w_cin};

        if (k == 0) begin : g_first
            assign w_a_in     = i_a;
            assign w_b_in     = i_b;
            assign w_sub_in   = i_sub;
            assign w_cin      = i_sub;
            assign w_valid_in = i_valid;
            assign w_sum_new  = w_chunk[C-1:0];
        end else begin : g_chain
            assign w_a_in     = g_stage[k-1].g_fwd.r_a;
            assign w_b_in     = g_stage[k-1].g_fwd.r_b;
            assign w_sub_in   = g_stage[k-1].g_fwd.r_sub;
            assign w_cin      = g_stage[k-1].g_fwd.r_carry;
            assign w_valid_in = g_stage[k-1].r_valid;
            assign w_sum_new  = {w_chunk[C-1:0], g_stage[k-1].g_fwd.r_sum};
        end

        // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's pre-edge value.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_valid <= 1'b0;
            end else if (w_adv) begin
                r_valid <= w_valid_in;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int RW = IW - C;

            logic [RW-1:0] r_a;
            logic [RW-1:0] r_b;
            logic          r_sub;
            logic          r_carry;
            logic [SW-1:0] r_sum;

            // NOTE: intermediate datapath registers are not reset; only the valid bits qualify their contents.
            always_ff @(posedge i_clk) begin
                if (w_adv) begin
                    r_a     <= w_a_in[IW-1:C];
                    r_b     <= w_b_in[IW-1:C];
                    r_sub   <= w_sub_in;
                    r_carry <= w_chunk[C];
                    r_sum   <= w_sum_new;
                end
            end
        end else begin : g_last
            logic          w_msb_cin;
            logic          w_cout;
            logic          w_ovf;
            logic [SW-1:0] r_sum;
            logic          r_cout;
            logic          r_ovf;
            logic          r_zero;
            logic          r_neg;

            // Carry into the MSB is recovered from the MSB sum bit and its two inputs.
            assign w_msb_cin = w_a_in[C-1] ^ w_bx[C-1] ^ w_chunk[C-1];
            assign w_ovf     = w_msb_cin ^ w_chunk[C];
            assign w_cout    = w_chunk[C] ^ w_sub_in;

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                    r_neg  <= 1'b0;
                end else if (w_adv) begin
                    r_sum  <= w_sum_new;
                    r_cout <= w_cout;
                    r_ovf  <= w_ovf;
                    r_zero <= ~|w_sum_new;
                    r_neg  <= w_sum_new[SW-1];
                end
            end
        end
    end

    assign o_valid = g_stage[STAGES-1].r_valid;
    assign o_sum   = g_stage[STAGES-1].g_last.r_sum;
    assign o_cout  = g_stage[STAGES-1].g_last.r_cout;
    assign o_ovf   = g_stage[STAGES-1].g_last.r_ovf;
    assign o_zero  = g_stage[STAGES-1].g_last.r_zero;
    assign o_neg   = g_stage[STAGES-1].g_last.r_neg;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=32, STAGES=4): directed corner vectors,
// a backpressured stream against an arithmetic model, and reset in mid-flight.
module tb_pipe_addsub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk;
    logic             i_reset;
    logic             i_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_sub;
    logic             o_valid;
    logic             i_out_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;
    logic             o_zero;
    logic             o_neg;

    int n_checks = 0;
    int n_errors = 0;

    pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_sub       (i_sub),
        .o_valid     (o_valid),
        .i_out_ready (i_out_ready),
        .o_sum       (o_sum),
        .o_cout      (o_cout),
        .o_ovf       (o_ovf),
        .o_zero      (o_zero),
        .o_neg       (o_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {sum, cout, ovf, zero, neg}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [32:0] r;
        logic        cout;
        logic        ovf;
        if (s) begin
            r    = {1'b0, a} - {1'b0, b};
            cout = (a < b);
            ovf  = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            r    = {1'b0, a} + {1'b0, b};
            cout = r[32];
            ovf  = (a[31] == b[31]) && (r[31] != a[31]);
        end
        return {r[31:0], cout, ovf, (r[31:0] == 32'd0), r[31]};
    endfunction

    function automatic logic [35:0] observed();
        return {o_sum, o_cout, o_ovf, o_zero, o_neg};
    endfunction

    // Entered and left #1 after a rising edge, with i_out_ready=1 and an empty pipe.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] e_sum, input logic e_cout,
                           input logic e_ovf, input logic e_zero, input logic e_neg);
        int lat;
        i_a     = a;
        i_b     = b;
        i_sub   = s;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"},  64'(lat),    64'(STAGES - 1));
        check({tag, "_sum"},  64'(o_sum),  64'(e_sum));
        check({tag, "_cout"}, 64'(o_cout), 64'(e_cout));
        check({tag, "_ovf"},  64'(o_ovf),  64'(e_ovf));
        check({tag, "_zero"}, 64'(o_zero), 64'(e_zero));
        check({tag, "_neg"},  64'(o_neg),  64'(e_neg));
        @(posedge clk); #1;
    endtask

    logic [35:0] exp_q[$];
    logic [35:0] held;
    logic [35:0] exp_v;
    logic        stalled;
    logic        fire;
    int          n_sent;
    int          n_got;

    initial begin
        i_reset     = 1'b1;
        i_valid     = 1'b0;
        i_a         = '0;
        i_b         = '0;
        i_sub       = 1'b0;
        i_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_sum",   64'(o_sum),   64'd0);
        check("rst_flags", 64'({o_cout, o_ovf, o_zero, o_neg}), 64'd0);
        i_reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(o_in_ready), 64'd1);

        run_one("carry_all",   32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_one("carry_chunk", 32'h00FF_FFFF, 32'h1, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_one("sub_borrow",  32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        run_one("sub_pos",     32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
        run_one("ovf_add",     32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_one("ovf_sub",     32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_one("sub_equal",   32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Stream of 16 ops with random input gaps and random output backpressure.
        n_sent  = 0;
        n_got   = 0;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 1000 && n_got < 16; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                check("stream_hold_valid", 64'(o_valid), 64'd1);
                check("stream_hold_data",  64'(observed()), 64'(held));
            end
            stalled = 1'b0;
            if (o_valid) begin
                if (i_out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("stream_extra", 64'd1, 64'd0);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("stream_result", 64'(observed()), 64'(exp_v));
                    end
                    n_got++;
                end else begin
                    held    = observed();
                    stalled = 1'b1;
                end
            end
            fire = i_valid & o_in_ready;
            @(posedge clk); #1;
            if (fire) begin
                exp_q.push_back(model(i_a, i_b, i_sub));
                n_sent++;
            end
            if (n_sent < 16 && $urandom_range(0, 3) != 0) begin
                i_a     = $urandom;
                i_b     = ($urandom_range(0, 3) == 0) ? i_a : $urandom;
                i_sub   = 1'($urandom_range(0, 1));
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            i_out_ready = ($urandom_range(0, 2) != 0);
        end
        check("stream_count", 64'(n_got), 64'd16);
        i_valid     = 1'b0;
        i_out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("stream_drained", 64'(o_valid), 64'd0);

        // Reset with three transactions in flight and a fourth offered during reset.
        for (int j = 0; j < 3; j++) begin
            i_a     = 32'h1000 * (j + 1);
            i_b     = 32'h1;
            i_sub   = 1'b0;
            i_valid = 1'b1;
            @(posedge clk); #1;
        end
        i_reset = 1'b1;
        i_a     = 32'hDEAD_BEEF;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_valid = 1'b0;
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_sum",   64'(o_sum),   64'd0);
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            check("midrst_idle", 64'(o_valid), 64'd0);
        end
        run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
